// File: rtl/nn_layer_sequencer.sv
// Sequences one fully-connected layer over a shared MAC datapath: per neuron it
// clears the accumulator, issues every input/weight pair, waits for the MAC
// pipeline to drain and then strobes the neuron result write.
module nn_layer_sequencer #(
    parameter int unsigned NUM_INPUTS  = 62,
    parameter int unsigned NUM_NEURONS = 20,
    parameter int unsigned MAC_LAT     = 2,
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned IDX_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_issue,
    output logic [IDX_W-1:0]  o_in_sel,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_acc_clr,
    output logic              o_acc_en,
    output logic              o_out_wr,
    output logic [IDX_W-1:0]  o_out_idx
);

    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_neuron_cnt;
    logic [IDX_W-1:0]   r_in_cnt;
    logic [ADDR_W-1:0]  r_base;
    logic [ADDR_W-1:0]  r_w_addr;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic [MAC_LAT-1:0] r_pipe;
    logic               r_busy;
    logic               r_done;
    logic               r_acc_clr;
    logic               r_out_wr;
    logic [IDX_W-1:0]   r_out_idx;

    logic w_issue;
    logic w_last_in;
    logic w_last_nrn;

    assign w_issue    = (r_state == S_ISSUE) && !i_stall;
    assign w_last_in  = (r_in_cnt == IDX_W'(NUM_INPUTS - 1));
    assign w_last_nrn = (r_neuron_cnt == IDX_W'(NUM_NEURONS - 1));

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_issue   = w_issue;
    assign o_in_sel  = r_in_cnt;
    assign o_w_addr  = r_w_addr;
    assign o_acc_clr = r_acc_clr;
    assign o_acc_en  = r_pipe[MAC_LAT-1];
    assign o_out_wr  = r_out_wr;
    assign o_out_idx = r_out_idx;

    // Issue-valid delay line matching the MAC latency; shifts every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe <= MAC_LAT'({r_pipe, w_issue});
        end
    end

    // Layer FSM with counters; in_cnt and w_addr are kept at zero outside ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_neuron_cnt <= '0;
            r_in_cnt     <= '0;
            r_base       <= '0;
            r_w_addr     <= '0;
            r_drain_cnt  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_out_wr     <= 1'b0;
            r_out_idx    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_acc_clr <= 1'b0;
            r_out_wr  <= 1'b0;
            r_out_idx <= '0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_CLR;
                        r_neuron_cnt <= '0;
                        r_base       <= '0;
                        r_busy       <= 1'b1;
                        r_acc_clr    <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_state  <= S_ISSUE;
                    r_in_cnt <= '0;
                    r_w_addr <= r_base;
                end
                S_ISSUE: begin
                    if (!i_stall) begin
                        if (w_last_in) begin
                            r_state     <= S_DRAIN;
                            r_in_cnt    <= '0;
                            r_w_addr    <= '0;
                            r_drain_cnt <= DRAIN_W'(MAC_LAT - 1);
                        end else begin
                            r_in_cnt <= r_in_cnt + IDX_W'(1);
                            r_w_addr <= r_w_addr + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        r_state   <= S_WRITE;
                        r_out_wr  <= 1'b1;
                        r_out_idx <= r_neuron_cnt;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - DRAIN_W'(1);
                    end
                end
                S_WRITE: begin
                    if (w_last_nrn) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_CLR;
                        r_neuron_cnt <= r_neuron_cnt + IDX_W'(1);
                        r_base       <= r_base + ADDR_W'(NUM_INPUTS);
                        r_acc_clr    <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
